// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter.
// Holds the FSM state encoding and grant identifiers.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } state_e;

   localparam logic GNT_I = 1'b0;
   localparam logic GNT_D = 1'b1;

   function automatic logic [1:0] gnt_onehot(input logic id);
      return (id == GNT_D) ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin select between fetch (bit 0) and data (bit 1).
// On contention the requester that did not win last time gets the grant.
module rr_arbiter2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      unique case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = (last == GNT_D) ? gnt_onehot(GNT_I)
                                        : gnt_onehot(GNT_D);
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between a fetch port and a load/store port.
// One transaction in flight: IDLE -> ACCESS -> WAIT -> RESP -> IDLE.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req_valid,
   output logic              i_req_ready,
   input  logic [ADDR_W-1:0] i_req_addr,
   output logic              i_rsp_valid,
   output logic [DATA_W-1:0] i_rsp_data,
   input  logic              d_req_valid,
   output logic              d_req_ready,
   input  logic [ADDR_W-1:0] d_req_addr,
   input  logic              d_req_we,
   input  logic [DATA_W-1:0] d_req_wdata,
   output logic              d_rsp_valid,
   output logic [DATA_W-1:0] d_rsp_data,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wd,
   input  logic [DATA_W-1:0] mem_rd
);

   state_e            state_q, state_d;
   logic              last_q, last_d;
   logic              id_q, id_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] wd_q, wd_d;
   logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

   logic [1:0]        req;
   logic [1:0]        gnt;
   logic              idle;
   logic              hs_i;
   logic              hs_d;

   assign req = {d_req_valid, i_req_valid};

   rr_arbiter2 u_rr (
      .req  (req),
      .last (last_q),
      .gnt  (gnt)
   );

   // Readiness is gated by rst_n so nothing is accepted during reset.
   assign idle        = (state_q == IDLE) && rst_n;
   assign i_req_ready = idle && gnt[GNT_I];
   assign d_req_ready = idle && gnt[GNT_D];
   assign hs_i        = i_req_valid && i_req_ready;
   assign hs_d        = d_req_valid && d_req_ready;

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      id_d      = id_q;
      addr_d    = addr_q;
      we_d      = we_q;
      wd_d      = wd_q;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
      unique case (state_q)
         IDLE: begin
            if (hs_i) begin
               state_d = ACCESS;
               last_d  = GNT_I;
               id_d    = GNT_I;
               addr_d  = i_req_addr;
               we_d    = 1'b0;
               wd_d    = '0;
            end else if (hs_d) begin
               state_d = ACCESS;
               last_d  = GNT_D;
               id_d    = GNT_D;
               addr_d  = d_req_addr;
               we_d    = d_req_we;
               wd_d    = d_req_wdata;
            end
         end
         ACCESS: state_d = WAIT;
         WAIT: begin
            state_d = RESP;
            if (id_q == GNT_I) begin
               i_rdata_d = mem_rd;
            end else begin
               d_rdata_d = we_q ? '0 : mem_rd;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         last_q    <= GNT_D;
         id_q      <= GNT_I;
         addr_q    <= '0;
         we_q      <= 1'b0;
         wd_q      <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         id_q      <= id_d;
         addr_q    <= addr_d;
         we_q      <= we_d;
         wd_q      <= wd_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
      end
   end

   // A reset landing mid-store must not let the write reach the RAM.
   assign mem_addr    = addr_q;
   assign mem_wd      = wd_q;
   assign mem_we      = (state_q == ACCESS) && we_q && rst_n;

   assign i_rsp_valid = (state_q == RESP) && (id_q == GNT_I);
   assign d_rsp_valid = (state_q == RESP) && (id_q == GNT_D);
   assign i_rsp_data  = i_rdata_q;
   assign d_rsp_data  = d_rdata_q;

   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (!(i_rsp_valid && d_rsp_valid));
         assert (gnt != 2'b11);
         assert (!(i_req_ready && d_req_ready));
      end
   end

endmodule
